prime_factorizer: RTL and testbench
===================================

// Module: prime_factorizer
// PURPOSE
//  Sequential trial-division factorizer, the generating counterpart of the combinational prime checker.
//  Accepts one unsigned number per job and streams its prime factors in ascending order.
//  Repeated factors are emitted individually (12 -> 2,2,3) over a valid/ready output channel.
//  At job end it reports the factor count and a prime flag.
//  Sits behind a number source and in front of a display/scoreboard consumer.
// PARAMETERS
//  WIDTH   8   bit width of number, factor, remainder and divisor
//  CNTW    4   width of factor_count; must hold WIDTH (max number of factors)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      accept number when idle (busy==0)
//  number        in   WIDTH  value to factor, sampled on accepted start
//  busy          out  1      job in progress; start ignored while 1
//  factor_valid  out  1      factor holds a valid prime factor
//  factor_ready  in   1      consumer accepts factor when valid&ready
//  factor        out  WIDTH  current prime factor
//  done          out  1      one-cycle pulse at job end
//  factor_count  out  CNTW   factors emitted this job; stable from done until next start
//  is_prime      out  1      1 iff factor_count==1 at done; stable until next start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs go to 0; the FSM goes to IDLE.
//   - An in-flight job is abandoned; no done is issued.
//  FSM states: IDLE, CHECK, EMIT, FINISH.
//  IDLE
//   - On start: rem<=number, div<=2, factor_count<=0, is_prime<=0, busy<=1.
//   - If number<2, go to FINISH; otherwise go to CHECK.
//  CHECK (one divisor test per cycle)
//   - If div*div > rem (2*WIDTH-bit product):
//     - rem>1: factor<=rem, last<=1, go to EMIT.
//     - otherwise: go to FINISH.
//   - Else if rem%div==0: factor<=div, rem<=rem/div, last<=0, go to EMIT.
//   - Else: div<=div+1, stay in CHECK.
//  EMIT
//   - factor_valid=1; factor is held stable until the handshake.
//   - On valid&ready: factor_count++, factor_valid<=0; go to FINISH if last, else CHECK.
//   - div is not incremented after a hit, so repeated factors are found.
//  FINISH
//   - done=1 for one cycle; is_prime<=(factor_count==1); busy<=0; go to IDLE.
//  Latency
//   - Start to first factor_valid: 1 + (divisors tried) cycles.
//   - Prime p: about sqrt(p) CHECK cycles.
//  Rules
//   - start is ignored while busy, including in the FINISH cycle.
//   - The next start is accepted the cycle after done.
//   - Numbers 0 and 1: no factors, done 2 cycles after start, count 0, is_prime 0.
//   - Arithmetic is unsigned. div never exceeds rem, so no overflow occurs.
//   - The product is compared at 2*WIDTH bits to avoid wrap at 255.
// STRUCTURE
//  - Shared include prime_defs.vh holds the state encodings (IDLE/CHECK/EMIT/FINISH) and the WIDTH default.
//  - One sub-module, prime_div_step: combinational (rem, div) -> (quot, is_div, sq_gt). It holds all divide/multiply logic.
//  - The FSM and datapath registers live in prime_factorizer.
// TESTING
//  1. number=12, ready=1 -> factors 2,2,3; count=3, is_prime=0; done pulses once.
//  2. number=97 -> single factor 97, count=1, is_prime=1; no factor before the div=10 check.
//  3. number=0 and number=1 -> no factor_valid; done 2 cycles after start; count=0, is_prime=0.
//  4. number=255 with ready low 5 cycles per factor -> 3,5,17 each held stable while stalled; count=3.
//  5. rst_n low during EMIT of number=200 -> outputs 0 immediately; fresh start 13 -> factor 13, is_prime=1.
//  6. start(15) pulsed again with 7 while busy -> second start ignored; factors 3,5 only.

Source files
------------

// File: rtl/prime_factorizer_pkg.sv
// -----------------------------------------------------------------------------
// prime_factorizer_pkg
//   Shared definitions for the trial-division prime factorizer: default
//   widths and the FSM state encoding used by prime_factorizer.
// -----------------------------------------------------------------------------
package prime_factorizer_pkg;

    localparam int WIDTH_DEF = 8;   // number / factor / remainder / divisor width
    localparam int CNTW_DEF  = 4;   // factor count width, must hold WIDTH

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/prime_factorizer_if.sv
// -----------------------------------------------------------------------------
// prime_factorizer_if
//   Job and factor-stream signals of the prime factorizer.
//   master : number source + factor consumer (drives start/number/factor_ready)
//   slave  : the factorizer (drives busy, factor stream, done, count, is_prime)
//   Signals:
//     start, number        job request, number sampled on accepted start
//     busy                 job in progress, start ignored while high
//     factor_valid/ready   valid/ready handshake for each prime factor
//     factor               current prime factor
//     done                 one-cycle pulse at job end
//     factor_count         factors emitted this job
//     is_prime             1 iff exactly one factor was emitted
// -----------------------------------------------------------------------------
interface prime_factorizer_if
    import prime_factorizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
);

    logic             start;
    logic [WIDTH-1:0] number;
    logic             busy;
    logic             factor_valid;
    logic             factor_ready;
    logic [WIDTH-1:0] factor;
    logic             done;
    logic [CNTW-1:0]  factor_count;
    logic             is_prime;

    modport master (
        output start, number, factor_ready,
        input  busy, factor_valid, factor, done, factor_count, is_prime
    );

    modport slave (
        input  start, number, factor_ready,
        output busy, factor_valid, factor, done, factor_count, is_prime
    );

endinterface

// File: rtl/prime_factorizer_div_step.sv
// -----------------------------------------------------------------------------
// prime_div_step
//   Combinational divisor test for one trial-division step.
//   Ports:
//     i_rem    current remainder
//     i_div    current trial divisor
//     o_quot   i_rem / i_div
//     o_is_div i_div divides i_rem exactly
//     o_sq_gt  i_div*i_div > i_rem, evaluated at 2*WIDTH bits so 16*16 etc.
//              never wrap
// -----------------------------------------------------------------------------
module prime_div_step
    import prime_factorizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_quot,
    output logic             o_is_div,
    output logic             o_sq_gt
);

    logic [2*WIDTH-1:0] w_div_ext;
    logic [2*WIDTH-1:0] w_sq;

    always_comb begin
        w_div_ext = {{WIDTH{1'b0}}, i_div};
        w_sq      = w_div_ext * w_div_ext;
        o_sq_gt   = (w_sq > {{WIDTH{1'b0}}, i_rem});
        // Divisor is 0 only while idle after reset; keep the divider defined.
        if (i_div == '0) begin
            o_quot   = '0;
            o_is_div = 1'b0;
        end else begin
            o_quot   = i_rem / i_div;
            o_is_div = ((i_rem % i_div) == '0);
        end
    end

endmodule

// File: rtl/prime_factorizer.sv
// -----------------------------------------------------------------------------
// prime_factorizer
//   Sequential trial-division factorizer. Accepts one number per job and
//   streams its prime factors in ascending order (repeated factors emitted
//   individually) over a valid/ready channel, then pulses done with the
//   factor count and a prime flag.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset, abandons any job without done
//     io_bus   prime_factorizer_if.slave (job request, factor stream, status)
// -----------------------------------------------------------------------------
module prime_factorizer
    import prime_factorizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    prime_factorizer_if.slave    io_bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_last;
    logic [WIDTH-1:0] r_factor;
    logic             r_factor_valid;
    logic             r_busy;
    logic             r_done;
    logic [CNTW-1:0]  r_count;
    logic             r_is_prime;

    logic [WIDTH-1:0] w_quot;
    logic             w_is_div;
    logic             w_sq_gt;

    prime_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem    (r_rem),
        .i_div    (r_div),
        .o_quot   (w_quot),
        .o_is_div (w_is_div),
        .o_sq_gt  (w_sq_gt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_rem          <= '0;
            r_div          <= '0;
            r_last         <= 1'b0;
            r_factor       <= '0;
            r_factor_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_count        <= '0;
            r_is_prime     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_rem      <= io_bus.number;
                        r_div      <= WIDTH'(2);
                        r_count    <= '0;
                        r_is_prime <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (io_bus.number < WIDTH'(2)) ? ST_FINISH : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_sq_gt) begin
                        // No divisor up to sqrt(rem): what is left is itself prime.
                        if (r_rem > WIDTH'(1)) begin
                            r_factor       <= r_rem;
                            r_last         <= 1'b1;
                            r_factor_valid <= 1'b1;
                            r_state        <= ST_EMIT;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end else if (w_is_div) begin
                        // Divisor kept as is so a repeated factor is found again.
                        r_factor       <= r_div;
                        r_rem          <= w_quot;
                        r_last         <= 1'b0;
                        r_factor_valid <= 1'b1;
                        r_state        <= ST_EMIT;
                    end else begin
                        r_div <= r_div + WIDTH'(1);
                    end
                end
                ST_EMIT: begin
                    if (io_bus.factor_ready) begin
                        r_count        <= r_count + CNTW'(1);
                        r_factor_valid <= 1'b0;
                        r_state        <= r_last ? ST_FINISH : ST_CHECK;
                    end
                end
                ST_FINISH: begin
                    r_done     <= 1'b1;
                    r_is_prime <= (r_count == CNTW'(1));
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.busy         = r_busy;
    assign io_bus.factor_valid = r_factor_valid;
    assign io_bus.factor       = r_factor;
    assign io_bus.done         = r_done;
    assign io_bus.factor_count = r_count;
    assign io_bus.is_prime     = r_is_prime;

endmodule

// File: tb/tb_prime_factorizer.sv
module tb_prime_factorizer;

    localparam int WIDTH  = 8;
    localparam int CNTW   = 4;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    prime_factorizer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    prime_factorizer #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: prime factors in ascending order by repeated division.
    task automatic ref_factors(input int n);
        int m;
        exp_q = {};
        m = n;
        for (int d = 2; d <= n && m > 1; d++) begin
            while (m % d == 0) begin
                exp_q.push_back(d);
                m = m / d;
            end
        end
    endtask

    // Cycles from start acceptance to first valid factor: one per divisor
    // tried, plus one; trials stop at the first divisor that divides or
    // whose square exceeds the number.
    function automatic int ref_first_lat(input int n);
        for (int d = 2; d <= 256; d++)
            if (d * d > n || n % d == 0) return d;
        return -1;
    endfunction

    task automatic run_job(input int n, input int stall, input bit rnd, input bit restart);
        int  cyc, first, done_cyc, waited, cur_stall, emitted, nexp;
        bit  done_seen;
        ref_factors(n);
        nexp      = exp_q.size();
        first     = -1;
        done_cyc  = -1;
        waited    = 0;
        cur_stall = 0;
        emitted   = 0;
        done_seen = 1'b0;
        bus.number = WIDTH'(n);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check($sformatf("busy_%0d", n), bus.busy, 1);
        while (!done_seen && cyc <= BUDGET) begin
            if (bus.factor_valid) begin
                if (first < 0) first = cyc;
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_factor_%0d", n), bus.factor_valid, 0);
                    bus.factor_ready = 1'b1;
                end else begin
                    if (waited == 0) cur_stall = rnd ? int'($urandom_range(0, 3)) : stall;
                    check($sformatf("factor_%0d_%0d", n, emitted), bus.factor, exp_q[0]);
                    if (waited < cur_stall) begin
                        bus.factor_ready = 1'b0;
                        waited++;
                    end else begin
                        bus.factor_ready = 1'b1;
                        void'(exp_q.pop_front());
                        emitted++;
                        waited = 0;
                    end
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check($sformatf("count_%0d", n), bus.factor_count, nexp);
                check($sformatf("is_prime_%0d", n), bus.is_prime, (nexp == 1) ? 1 : 0);
                check($sformatf("emitted_%0d", n), emitted, nexp);
                check($sformatf("busy_at_done_%0d", n), bus.busy, 0);
            end
            if (restart && cyc == 2) begin
                bus.number = WIDTH'(7);
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("done_seen_%0d", n), done_seen, 1);
        if (n >= 2) check($sformatf("first_lat_%0d", n), first, ref_first_lat(n));
        else begin
            check($sformatf("no_valid_%0d", n), first, -1);
            check($sformatf("done_lat_%0d", n), done_cyc, 2);
        end
        check($sformatf("done_pulse_%0d", n), bus.done, 0);
        check($sformatf("count_hold_%0d", n), bus.factor_count, nexp);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.number       = '0;
        bus.factor_ready = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   bus.busy, 0);
        check("rst_valid",  bus.factor_valid, 0);
        check("rst_factor", bus.factor, 0);
        check("rst_done",   bus.done, 0);
        check("rst_count",  bus.factor_count, 0);
        check("rst_prime",  bus.is_prime, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(12, 0, 1'b0, 1'b0);
        run_job(97, 0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);
        run_job(1, 0, 1'b0, 1'b0);
        run_job(255, 5, 1'b0, 1'b0);

        // Abandon a job mid-emit with an asynchronous reset.
        bus.factor_ready = 1'b0;
        bus.number       = WIDTH'(200);
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.factor_valid; i++) @(negedge clk);
        check("pre_rst_valid",  bus.factor_valid, 1);
        check("pre_rst_factor", bus.factor, 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  bus.factor_valid, 0);
        check("async_rst_factor", bus.factor, 0);
        check("async_rst_busy",   bus.busy, 0);
        check("async_rst_count",  bus.factor_count, 0);
        check("async_rst_done",   bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", bus.done, 0);
        end
        run_job(13, 0, 1'b0, 1'b0);

        run_job(15, 0, 1'b0, 1'b1);

        run_job(2, 0, 1'b0, 1'b0);
        run_job(4, 1, 1'b0, 1'b0);
        run_job(128, 0, 1'b1, 1'b0);
        run_job(251, 0, 1'b0, 1'b0);
        run_job(254, 2, 1'b0, 1'b0);
        for (int j = 0; j < 25; j++) run_job(int'($urandom_range(0, 255)), 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
